// File: rtl/reg_decr_val_rdy.sv
// Receive-side decrementer: accepts incremented values on a val/rdy stream, stores value-1 in a
// small FIFO and presents them in order. Define REG_DECR_UNDERFLOW_EN to add the out_uflow flag.
module reg_decr_val_rdy #(
  parameter int NBITS = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NBITS-1:0]           in_,
  input  logic                       in_val,
  output logic                       in_rdy,
  output logic [NBITS-1:0]           out,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef REG_DECR_UNDERFLOW_EN
  ,
  output logic                       out_uflow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
`ifdef REG_DECR_UNDERFLOW_EN
  localparam int EW = NBITS + 1;
`else
  localparam int EW = NBITS;
`endif

  // Handshake: a beat transfers on the rising edge where val && rdy; in_rdy and out_val
  // depend only on registered state (and reset), never on the partner's val/rdy.
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             enq, deq;
  logic [EW-1:0]    new_entry;
  logic [EW-1:0]    head_entry;
  logic [NBITS-1:0] dec_val;

  assign in_rdy     = !reset && (count_q != CW'(DEPTH));
  assign out_val    = (count_q != '0);
  assign count      = count_q;
  assign head_entry = mem_q[head_q];
  assign out        = out_val ? head_entry[NBITS-1:0] : '0;
`ifdef REG_DECR_UNDERFLOW_EN
  assign out_uflow  = out_val ? head_entry[NBITS] : 1'b0;
`endif

  always_comb begin
    enq     = in_val && in_rdy;
    deq     = out_val && out_rdy;
    dec_val = in_ - {{(NBITS-1){1'b0}}, 1'b1};
`ifdef REG_DECR_UNDERFLOW_EN
    new_entry = {(in_ == '0), dec_val};
`else
    new_entry = dec_val;
`endif
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      mem_d[tail_q] = new_entry;
      tail_d = (tail_q == PW'(DEPTH-1)) ? '0 : tail_q + PW'(1);
    end
    if (deq) begin
      head_d = (head_q == PW'(DEPTH-1)) ? '0 : head_q + PW'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_reg_decr_val_rdy.sv
// Bench for reg_decr_val_rdy: directed vector table followed by a scoreboarded val/rdy stream.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_reg_decr_val_rdy;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] out;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] count;
  logic       out_uflow;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  reg_decr_val_rdy #(.NBITS(8), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_(in_), .in_val(in_val), .in_rdy(in_rdy),
    .out(out), .out_val(out_val), .out_rdy(out_rdy), .count(count)
`ifdef REG_DECR_UNDERFLOW_EN
    , .out_uflow(out_uflow)
`endif
  );

`ifndef REG_DECR_UNDERFLOW_EN
  assign out_uflow = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       e_rdy;
    logic       e_oval;
    logic [7:0] e_out;
    logic [1:0] e_cnt;
    logic       e_uf;
  } vec_t;

  vec_t vecs[31];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [7:0] din, input logic ordy);
    reset   = rst;
    in_val  = iv;
    in_     = din;
    out_rdy = ordy;
  endtask

  task automatic set_vec(input int i, input logic rst, input logic iv, input logic [7:0] din,
                         input logic ordy, input logic e_rdy, input logic e_oval,
                         input logic [7:0] e_out, input logic [1:0] e_cnt, input logic e_uf);
    vecs[i] = '{rst, iv, din, ordy, e_rdy, e_oval, e_out, e_cnt, e_uf};
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Expected columns describe the cycle in which the row's inputs are applied.
    //          rst iv  din    ordy rdy oval out    cnt uf
    for (int i = 0; i < 5; i++)
      set_vec(i, 0, 0, 8'h00, i[0], 1, 0, 8'h00, 0, 0);
    set_vec(5,  0, 1, 8'h05, 1, 1, 0, 8'h00, 0, 0);
    set_vec(6,  0, 1, 8'h01, 1, 1, 1, 8'h04, 1, 0);
    set_vec(7,  0, 1, 8'h80, 1, 1, 1, 8'h00, 1, 0);
    set_vec(8,  0, 0, 8'h00, 1, 1, 1, 8'h7F, 1, 0);
    set_vec(9,  0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    set_vec(10, 0, 1, 8'h10, 0, 1, 0, 8'h00, 0, 0);
    set_vec(11, 0, 1, 8'h11, 0, 1, 1, 8'h0F, 1, 0);
    set_vec(12, 0, 1, 8'h12, 0, 0, 1, 8'h0F, 2, 0);
    set_vec(13, 0, 1, 8'h12, 0, 0, 1, 8'h0F, 2, 0);
    set_vec(14, 0, 1, 8'h12, 1, 0, 1, 8'h0F, 2, 0);
    set_vec(15, 0, 1, 8'h12, 1, 1, 1, 8'h10, 1, 0);
    set_vec(16, 0, 0, 8'h00, 1, 1, 1, 8'h11, 1, 0);
    set_vec(17, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    set_vec(18, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    set_vec(19, 0, 1, 8'hFF, 0, 1, 1, 8'hFF, 1, 1);
    set_vec(20, 0, 0, 8'h00, 1, 0, 1, 8'hFF, 2, 1);
    set_vec(21, 0, 0, 8'h00, 1, 1, 1, 8'hFE, 1, 0);
    set_vec(22, 0, 1, 8'h01, 1, 1, 0, 8'h00, 0, 0);
    set_vec(23, 0, 0, 8'h00, 0, 1, 1, 8'h00, 1, 0);
    set_vec(24, 0, 1, 8'hAA, 0, 1, 1, 8'h00, 1, 0);
    set_vec(25, 1, 1, 8'h33, 0, 0, 1, 8'h00, 2, 0);
    set_vec(26, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
    set_vec(27, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
    set_vec(28, 0, 1, 8'h42, 1, 1, 0, 8'h00, 0, 0);
    set_vec(29, 0, 0, 8'h00, 1, 1, 1, 8'h41, 1, 0);
    set_vec(30, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      @(negedge clk);
      check("in_rdy",  i, 32'(in_rdy),  32'(vecs[i].e_rdy));
      check("out_val", i, 32'(out_val), 32'(vecs[i].e_oval));
      check("out",     i, 32'(out),     32'(vecs[i].e_out));
      check("count",   i, 32'(count),   32'(vecs[i].e_cnt));
`ifdef REG_DECR_UNDERFLOW_EN
      check("out_uflow", i, 32'(out_uflow), 32'(vecs[i].e_uf));
`endif
      @(posedge clk);
      #1;
    end

    // Scoreboarded stream with irregular val/rdy; then a bounded drain.
    exp_q.delete();
    for (int c = 0; c < 80; c++) begin
      logic       iv, ordy, do_enq, do_deq;
      logic [7:0] din;
      logic [8:0] exp_e;
      if (c < 60) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        din  = 8'($urandom_range(0, 255));
        if (c % 17 == 3) din = 8'h00;
      end else begin
        iv   = 1'b0;
        ordy = 1'b1;
        din  = 8'h00;
      end
      drive(1'b0, iv, din, ordy);
      do_deq = ordy && (exp_q.size() != 0);
      do_enq = iv && (exp_q.size() != 2);
      @(negedge clk);
      check("s_count",   c, 32'(count),   32'(exp_q.size()));
      check("s_out_val", c, 32'(out_val), 32'(exp_q.size() != 0));
      check("s_in_rdy",  c, 32'(in_rdy),  32'(exp_q.size() != 2));
      if (do_deq) begin
        exp_e = exp_q.pop_front();
        check("s_out", c, 32'(out), 32'(exp_e[7:0]));
`ifdef REG_DECR_UNDERFLOW_EN
        check("s_out_uflow", c, 32'(out_uflow), 32'(exp_e[8]));
`endif
      end
      if (do_enq) exp_q.push_back({(din == 8'h00), 8'(din - 8'h01)});
      @(posedge clk);
      #1;
    end
    check("drain_left", 0, 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
